// File: rtl/frame_scan_if.sv
// frame_scan_if: start/status, frame RAM port and pixel stream between the scan reader and the display driver.
interface frame_scan_if #(
    parameter int ROW_W = 4
);
    logic             start_in;
    logic [ROW_W-1:0] row_in;
    logic [2:0]       plane_in;
    logic             busy_out;
    logic             done_out;
    logic             ram_en_out;
    logic [15:0]      ram_addr_out;
    logic [23:0]      ram_data_in;
    logic             pix_valid_out;
    logic             pix_ready_in;
    logic [2:0]       rgb_top_out;
    logic [2:0]       rgb_bot_out;
    logic             last_out;

    modport master (
        output start_in, row_in, plane_in, ram_data_in, pix_ready_in,
        input  busy_out, done_out, ram_en_out, ram_addr_out, pix_valid_out,
               rgb_top_out, rgb_bot_out, last_out
    );

    modport slave (
        input  start_in, row_in, plane_in, ram_data_in, pix_ready_in,
        output busy_out, done_out, ram_en_out, ram_addr_out, pix_valid_out,
               rgb_top_out, rgb_bot_out, last_out
    );
endinterface

// File: rtl/frame_scan_reader.sv
// frame_scan_reader: reads a top/bottom row pair column by column from frame RAM and streams one bit-plane per pixel.
module frame_scan_reader #(
    parameter int NUM_ROWS = 32,
    parameter int NUM_COLS = 64,
    parameter int ROW_W    = 4,
    parameter int COL_W    = 6
) (
    input logic          clk_in,
    input logic          reset_in,
    frame_scan_if.slave  bus
);
    typedef enum logic [2:0] {IDLE, RD_TOP, RD_BOT, CAPTURE, OUT} state_t;

    state_t           state;
    logic [ROW_W-1:0] row;
    logic [2:0]       plane;
    logic [COL_W-1:0] col;
    logic [2:0]       top_bits;
    logic [23:0]      shifted;
    logic [2:0]       bits;

    function automatic logic [15:0] addr(input logic [ROW_W-1:0] r, input logic [COL_W-1:0] c, input logic bot);
        return (16'(r) + (bot ? 16'(NUM_ROWS / 2) : 16'd0)) * 16'(NUM_COLS) + 16'(c);
    endfunction

    // Shifting by the plane lines bit p of every channel up at bits 16, 8 and 0.
    assign shifted = bus.ram_data_in >> plane;
    assign bits    = {shifted[16], shifted[8], shifted[0]};

    always_ff @(posedge clk_in or posedge reset_in) begin
        if (reset_in) begin
            state             <= IDLE;
            row               <= '0;
            plane             <= '0;
            col               <= '0;
            top_bits          <= '0;
            bus.busy_out      <= 1'b0;
            bus.done_out      <= 1'b0;
            bus.ram_en_out    <= 1'b0;
            bus.ram_addr_out  <= '0;
            bus.pix_valid_out <= 1'b0;
            bus.rgb_top_out   <= '0;
            bus.rgb_bot_out   <= '0;
            bus.last_out      <= 1'b0;
        end else begin
            bus.done_out <= 1'b0;
            case (state)
                IDLE: if (bus.start_in) begin
                    row              <= bus.row_in;
                    plane            <= bus.plane_in;
                    col              <= '0;
                    state            <= RD_TOP;
                    bus.busy_out     <= 1'b1;
                    bus.ram_en_out   <= 1'b1;
                    bus.ram_addr_out <= addr(bus.row_in, '0, 1'b0);
                end
                RD_TOP: begin
                    state            <= RD_BOT;
                    bus.ram_addr_out <= addr(row, col, 1'b1);
                end
                RD_BOT: begin
                    top_bits       <= bits;
                    bus.ram_en_out <= 1'b0;
                    state          <= CAPTURE;
                end
                CAPTURE: begin
                    bus.rgb_top_out   <= top_bits;
                    bus.rgb_bot_out   <= bits;
                    bus.pix_valid_out <= 1'b1;
                    bus.last_out      <= col == COL_W'(NUM_COLS - 1);
                    state             <= OUT;
                end
                OUT: if (bus.pix_ready_in) begin
                    bus.pix_valid_out <= 1'b0;
                    bus.last_out      <= 1'b0;
                    if (bus.last_out) begin
                        state        <= IDLE;
                        bus.done_out <= 1'b1;
                        bus.busy_out <= 1'b0;
                    end else begin
                        col              <= col + 1'b1;
                        state            <= RD_TOP;
                        bus.ram_en_out   <= 1'b1;
                        bus.ram_addr_out <= addr(row, col + 1'b1, 1'b0);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
